filtering_control_unit_param: RTL

FILTERING_CONTROL_UNIT_PARAM -- requirements
Module: filtering_control_unit_param

---
 rtl/filtering_pkg.sv | 19 +
 rtl/filtering_tap_counter.sv | 52 +++++
 rtl/filtering_control_unit_param.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/filtering_pkg.sv
// Shared definitions for the filtering control unit: default bus width,
// FSM state encoding and the index-width helper.
package filtering_pkg;

  localparam int DIMM_BUS_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_MAC  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filtering_tap_counter.sv
// Nested kernel/row/column tap counter. c is innermost, k outermost.
// The wrap flags are combinational and describe the current tap, so the
// parent can act on the final tap in the same cycle it is presented.
module filtering_tap_counter
  import filtering_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNELS = 1,
  parameter int TAP_W       = idx_w(KERNEL_SIZE),
  parameter int KIDX_W      = idx_w(NUM_KERNELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  output logic [TAP_W-1:0]  r,
  output logic [TAP_W-1:0]  c,
  output logic [KIDX_W-1:0] k,
  output logic              c_wrap,
  output logic              r_wrap,
  output logic              k_wrap
);

  localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(KERNEL_SIZE - 1);
  localparam logic [KIDX_W-1:0] K_LAST   = KIDX_W'(NUM_KERNELS - 1);

  assign c_wrap = (c == TAP_LAST);
  assign r_wrap = c_wrap && (r == TAP_LAST);
  assign k_wrap = r_wrap && (k == K_LAST);

  // Advance c, carrying into r and then k; clear returns to tap (0,0,0).
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r <= '0;
      c <= '0;
      k <= '0;
    end else if (step) begin
      if (c_wrap) begin
        c <= '0;
        if (r == TAP_LAST) begin
          r <= '0;
          k <= (k == K_LAST) ? '0 : k + 1'b1;
        end else begin
          r <= r + 1'b1;
        end
      end else begin
        c <= c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/filtering_control_unit_param.sv
// Filtering control unit: walks a "valid" convolution over a W x H frame,
// requesting one input window per output pixel and then issuing
// NUM_KERNELS*K*K tap strobes for it.
// Optional build macro FILTERING_CTRL_ABORT_EN adds an abort input that
// drops an in-flight frame (REQ/MAC) back to IDLE without a done pulse.
//
// state  | meaning
// IDLE   | waiting for start; frame size latched on start
// REQ    | req_pix high until the window-ready ack is sampled
// MAC    | one tap per cycle, k outer / r middle / c inner
// DONE   | one-cycle done pulse, then IDLE
module filtering_control_unit_param #(
  parameter  int DIMM_BUS_WIDTH = filtering_pkg::DIMM_BUS_WIDTH,
  parameter  int KERNEL_SIZE    = 3,
  parameter  int NUM_KERNELS    = 1,
  localparam int TAP_W          = filtering_pkg::idx_w(KERNEL_SIZE),
  localparam int KIDX_W         = filtering_pkg::idx_w(NUM_KERNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef FILTERING_CTRL_ABORT_EN
  input  logic                      abort,
`endif
  input  logic [DIMM_BUS_WIDTH-1:0] frame_input_width,
  input  logic [DIMM_BUS_WIDTH-1:0] frame_input_height,
  input  logic                      start,
  output logic                      done,
  output logic [TAP_W-1:0]          offset,
  output logic [TAP_W-1:0]          addr,
  output logic [KIDX_W-1:0]         kernel_idx,
  output logic                      en,
  output logic                      last_kernel,
  input  logic                      pix_ctrl_ack,
  output logic                      req_pix,
  output logic                      new_line
);

  import filtering_pkg::*;

  localparam logic [DIMM_BUS_WIDTH-1:0] K_DW = DIMM_BUS_WIDTH'(KERNEL_SIZE);

  state_t                    state;
  logic [DIMM_BUS_WIDTH-1:0] w_lat;
  logic [DIMM_BUS_WIDTH-1:0] h_lat;
  logic [DIMM_BUS_WIDTH-1:0] col;
  logic [DIMM_BUS_WIDTH-1:0] row;
  logic                      new_line_q;
  logic                      in_mac;
  logic                      abort_hit;
  logic [TAP_W-1:0]          tap_r;
  logic [TAP_W-1:0]          tap_c;
  logic [KIDX_W-1:0]         tap_k;
  logic                      c_wrap;
  logic                      r_wrap;
  logic                      k_wrap;

  assign in_mac = (state == S_MAC);

`ifdef FILTERING_CTRL_ABORT_EN
  assign abort_hit = abort && ((state == S_REQ) || (state == S_MAC));
`else
  assign abort_hit = 1'b0;
`endif

  // Tap counter runs only in MAC and sits at zero everywhere else.
  filtering_tap_counter #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .NUM_KERNELS (NUM_KERNELS),
    .TAP_W       (TAP_W),
    .KIDX_W      (KIDX_W)
  ) u_tap_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_mac || abort_hit),
    .step   (in_mac),
    .r      (tap_r),
    .c      (tap_c),
    .k      (tap_k),
    .c_wrap (c_wrap),
    .r_wrap (r_wrap),
    .k_wrap (k_wrap)
  );

  // Frame sequencing: state, latched frame size and output-pixel position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      w_lat      <= '0;
      h_lat      <= '0;
      col        <= '0;
      row        <= '0;
      new_line_q <= 1'b0;
    end else begin
      new_line_q <= 1'b0;
      if (abort_hit) begin
        state <= S_IDLE;
        col   <= '0;
        row   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              w_lat <= frame_input_width;
              h_lat <= frame_input_height;
              col   <= '0;
              row   <= '0;
              // A frame smaller than the kernel has no valid output pixel.
              if ((frame_input_width < K_DW) || (frame_input_height < K_DW))
                state <= S_DONE;
              else
                state <= S_REQ;
            end
          end
          S_REQ: begin
            if (pix_ctrl_ack) state <= S_MAC;
          end
          S_MAC: begin
            if (k_wrap) begin
              if (col == w_lat - K_DW) begin
                col        <= '0;
                new_line_q <= 1'b1;
                if (row == h_lat - K_DW) begin
                  row   <= '0;
                  state <= S_DONE;
                end else begin
                  row   <= row + 1'b1;
                  state <= S_REQ;
                end
              end else begin
                col   <= col + 1'b1;
                state <= S_REQ;
              end
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Outputs decode from registered state; tap indices forced to zero off-MAC.
  always_comb begin
    req_pix     = (state == S_REQ);
    done        = (state == S_DONE);
    en          = in_mac;
    offset      = in_mac ? tap_r : '0;
    addr        = in_mac ? tap_c : '0;
    kernel_idx  = in_mac ? tap_k : '0;
    last_kernel = in_mac && r_wrap;
    new_line    = new_line_q;
  end

endmodule
